pecell_mc: RTL



---
 rtl/pecell_mc.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pecell_mc.sv
// pecell_mc - multi-lane processing-element cell.
//
// Loads operands into a local buffer, runs lane-wise signed multiply-accumulate
// of an input stream against the buffer, and streams buffer contents back out.
// Configured through a small APB register slave.
//
// Ports:
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_pe_id                            cell identifier (readable at APB 0x4)
//   i_psel/i_penable/i_pwrite/i_paddr/i_pwdata, o_prdata/o_pready
//                                      APB slave, zero wait states
//   i_cs_n/i_cvalid/i_work_mode/i_waddr
//                                      command port (0 LOAD, 1 MAC, 2 READ)
//   i_wdata/i_wdata_valid/i_wdata_last, o_wdata_busy
//                                      input beat stream
//   o_rdata/o_rdata_valid/o_rdata_last, i_rdata_busy
//                                      output beat stream
//   o_pe_busy                          command in progress
//
// Build option: define PECELL_SAT_EN to clamp MAC lane results to the signed
// LANE_W range (and flag STATUS.sat_hit); otherwise lane results are truncated.
//
// state   | meaning
// --------+------------------------------------------------
// S_IDLE  | waiting for a command
// S_LOAD  | writing input beats into the buffer
// S_MAC   | accumulating input beats x buffer, per lane
// S_DRAIN | presenting the single MAC result beat
// S_READ  | streaming RLEN+1 buffer entries out

module pecell_mc #(
   parameter int WID_BUS  = 32,
   parameter int NUM_LANE = 4,
   parameter int DEPTH    = 32,
   parameter int ID_W     = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [ID_W-1:0]    i_pe_id,
   input  logic               i_psel,
   input  logic               i_penable,
   input  logic               i_pwrite,
   input  logic [3:0]         i_paddr,
   input  logic [7:0]         i_pwdata,
   output logic [7:0]         o_prdata,
   output logic               o_pready,
   input  logic               i_cs_n,
   input  logic               i_cvalid,
   input  logic [1:0]         i_work_mode,
   input  logic [AW-1:0]      i_waddr,
   input  logic [WID_BUS-1:0] i_wdata,
   input  logic               i_wdata_valid,
   input  logic               i_wdata_last,
   output logic               o_wdata_busy,
   output logic [WID_BUS-1:0] o_rdata,
   output logic               o_rdata_valid,
   output logic               o_rdata_last,
   input  logic               i_rdata_busy,
   output logic               o_pe_busy
);

   localparam int LANE_W = WID_BUS / NUM_LANE;
   localparam int ACC_W  = 2 * LANE_W + 8;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_READ} state_t;

   state_t r_state, w_state_nxt;

   logic                     r_en;
   logic [4:0]               r_shift;
   logic [7:0]               r_rlen;
   logic                     r_cmd_drop;
   logic                     r_mode_err;
   logic                     r_sat_hit;
   logic [AW-1:0]            r_ptr;
   logic [7:0]               r_cnt;
   logic [WID_BUS-1:0]       r_rdata;
   logic                     r_rdata_valid;
   logic                     r_rdata_last;
   logic signed [ACC_W-1:0]  r_acc [NUM_LANE];
   logic [WID_BUS-1:0]       r_buf [DEPTH];

   logic                     w_apb_wr, w_apb_rd, w_w1c;
   logic                     w_cmd, w_accept, w_drop_set, w_mode_err_set, w_sat_set;
   logic                     w_win, w_rcons, w_mac_last;
   logic [WID_BUS-1:0]       w_buf_rd, w_buf_wa;
   logic signed [LANE_W-1:0]   w_op_a [NUM_LANE];
   logic signed [LANE_W-1:0]   w_op_b [NUM_LANE];
   logic signed [2*LANE_W-1:0] w_prod [NUM_LANE];
   logic signed [ACC_W-1:0]    w_acc_nxt [NUM_LANE];
   logic [WID_BUS-1:0]       w_res;
   logic                     w_sat_any;
`ifdef PECELL_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-LANE_W+1){1'b1}}, {(LANE_W-1){1'b0}}};
   logic signed [ACC_W-1:0]  w_shr [NUM_LANE];
`endif

   assign o_pready      = 1'b1;
   assign o_pe_busy     = (r_state != S_IDLE);
   assign o_wdata_busy  = !((r_state == S_LOAD) || (r_state == S_MAC));
   assign o_rdata       = r_rdata;
   assign o_rdata_valid = r_rdata_valid;
   assign o_rdata_last  = r_rdata_last;

   assign w_apb_wr       = i_psel & i_penable & i_pwrite;
   assign w_apb_rd       = i_psel & i_penable & ~i_pwrite;
   assign w_w1c          = w_apb_wr & (i_paddr == 4'h3);
   assign w_cmd          = i_cvalid & ~i_cs_n;
   assign w_accept       = w_cmd & r_en & (r_state == S_IDLE);
   assign w_drop_set     = w_cmd & (r_state != S_IDLE);
   assign w_mode_err_set = w_accept & (i_work_mode == 2'd3);
   assign w_win          = i_wdata_valid & ~o_wdata_busy;
   assign w_rcons        = r_rdata_valid & ~i_rdata_busy;
   assign w_mac_last     = (r_state == S_MAC) & w_win & i_wdata_last;
   assign w_sat_set      = w_mac_last & w_sat_any;
   assign w_buf_rd       = r_buf[r_ptr];
   // READ presents its first beat on the accept edge, before r_ptr is loaded.
   assign w_buf_wa       = r_buf[i_waddr];

   always_comb begin
      o_prdata = '0;
      if (w_apb_rd) begin
         case (i_paddr)
            4'h0:    o_prdata = {7'b0, r_en};
            4'h1:    o_prdata = {3'b0, r_shift};
            4'h2:    o_prdata = r_rlen;
            4'h3:    o_prdata = {4'b0, r_sat_hit, r_mode_err, r_cmd_drop, o_pe_busy};
            4'h4:    o_prdata = 8'(i_pe_id);
            default: o_prdata = '0;
         endcase
      end
   end

   // The result beat is formed from the accumulator value including the
   // final beat, so it can be registered on the same edge that beat lands.
   always_comb begin
      w_res     = '0;
      w_sat_any = 1'b0;
      for (int l = 0; l < NUM_LANE; l++) begin
         w_op_a[l]    = $signed(i_wdata[l*LANE_W +: LANE_W]);
         w_op_b[l]    = $signed(w_buf_rd[l*LANE_W +: LANE_W]);
         w_prod[l]    = w_op_a[l] * w_op_b[l];
         w_acc_nxt[l] = r_acc[l] + $signed({{(ACC_W-2*LANE_W){w_prod[l][2*LANE_W-1]}}, w_prod[l]});
`ifdef PECELL_SAT_EN
         w_shr[l] = w_acc_nxt[l] >>> r_shift;
         if (w_shr[l] > SAT_MAX) begin
            w_res[l*LANE_W +: LANE_W] = SAT_MAX[LANE_W-1:0];
            w_sat_any = 1'b1;
         end else if (w_shr[l] < SAT_MIN) begin
            w_res[l*LANE_W +: LANE_W] = SAT_MIN[LANE_W-1:0];
            w_sat_any = 1'b1;
         end else begin
            w_res[l*LANE_W +: LANE_W] = w_shr[l][LANE_W-1:0];
         end
`else
         w_res[l*LANE_W +: LANE_W] = LANE_W'(w_acc_nxt[l] >>> r_shift);
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (i_work_mode)
                  2'd0:    w_state_nxt = S_LOAD;
                  2'd1:    w_state_nxt = S_MAC;
                  2'd2:    w_state_nxt = S_READ;
                  default: w_state_nxt = S_IDLE;
               endcase
            end
         end
         S_LOAD:  if (w_win && i_wdata_last) w_state_nxt = S_IDLE;
         S_MAC:   if (w_win && i_wdata_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_rcons) w_state_nxt = S_IDLE;
         S_READ:  if (w_rcons && (r_cnt == 8'd0)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Buffer has no reset so its contents survive a reset pulse.
   always_ff @(posedge i_clk) begin
      if ((r_state == S_LOAD) && w_win) r_buf[r_ptr] <= i_wdata;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_en          <= 1'b0;
         r_shift       <= '0;
         r_rlen        <= '0;
         r_cmd_drop    <= 1'b0;
         r_mode_err    <= 1'b0;
         r_sat_hit     <= 1'b0;
         r_ptr         <= '0;
         r_cnt         <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_rdata_last  <= 1'b0;
         for (int l = 0; l < NUM_LANE; l++) r_acc[l] <= '0;
      end else begin
         if (w_apb_wr) begin
            case (i_paddr)
               4'h0:    r_en    <= i_pwdata[0];
               4'h1:    r_shift <= i_pwdata[4:0];
               4'h2:    r_rlen  <= i_pwdata;
               default: ;
            endcase
         end
         // Set events override a simultaneous write-one-to-clear.
         r_cmd_drop <= w_drop_set     | (r_cmd_drop & ~(w_w1c & i_pwdata[1]));
         r_mode_err <= w_mode_err_set | (r_mode_err & ~(w_w1c & i_pwdata[2]));
         r_sat_hit  <= w_sat_set      | (r_sat_hit  & ~(w_w1c & i_pwdata[3]));

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ptr <= i_waddr;
                  for (int l = 0; l < NUM_LANE; l++) r_acc[l] <= '0;
                  if (i_work_mode == 2'd2) begin
                     r_rdata       <= w_buf_wa;
                     r_rdata_valid <= 1'b1;
                     r_rdata_last  <= (r_rlen == 8'd0);
                     r_cnt         <= r_rlen;
                     r_ptr         <= i_waddr + AW'(1);
                  end
               end
            end
            S_LOAD: begin
               if (w_win) r_ptr <= r_ptr + AW'(1);
            end
            S_MAC: begin
               if (w_win) begin
                  r_ptr <= r_ptr + AW'(1);
                  for (int l = 0; l < NUM_LANE; l++) r_acc[l] <= w_acc_nxt[l];
                  if (i_wdata_last) begin
                     r_rdata       <= w_res;
                     r_rdata_valid <= 1'b1;
                     r_rdata_last  <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (w_rcons) begin
                  r_rdata_valid <= 1'b0;
                  r_rdata_last  <= 1'b0;
               end
            end
            S_READ: begin
               if (w_rcons) begin
                  if (r_cnt == 8'd0) begin
                     r_rdata_valid <= 1'b0;
                     r_rdata_last  <= 1'b0;
                  end else begin
                     r_rdata      <= w_buf_rd;
                     r_ptr        <= r_ptr + AW'(1);
                     r_cnt        <= r_cnt - 8'd1;
                     r_rdata_last <= (r_cnt == 8'd1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
